// File: rtl/nios_system_tile_fetcher.sv
// Burst reader: streams word_count words from a 1-cycle-latency on-chip RAM
// into a small first-word-fall-through buffer feeding a ready/valid consumer.
module nios_system_tile_fetcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W:0]   remaining_issue;
    logic [ADDR_W:0]   remaining_xfer;
    logic              inflight;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occ_next;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'b1111;
    assign out_valid      = (fifo_count != '0);
    assign out_data       = out_valid ? fifo_mem[rd_ptr] : '0;
    assign busy           = (state != S_IDLE);

    assign push = inflight;
    assign pop  = out_valid && out_ready;

    // Occupancy after this cycle's returning word lands and any departing word leaves;
    // a new read may be issued only if its word will still fit.
    always_comb begin
        occ_next = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        issue    = (state == S_FETCH) && (remaining_issue != '0) && (occ_next < DEPTH_L);
    end

    assign mem_chipselect = issue;
    assign mem_address    = issue ? next_addr : last_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            next_addr       <= '0;
            last_addr       <= '0;
            remaining_issue <= '0;
            remaining_xfer  <= '0;
            inflight        <= 1'b0;
            done            <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            next_addr       <= base_addr;
                            remaining_issue <= word_count;
                            remaining_xfer  <= word_count;
                            state           <= S_FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue && remaining_issue == 1) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && remaining_xfer == 1) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (issue) begin
                next_addr       <= next_addr + 1'b1;
                last_addr       <= next_addr;
                remaining_issue <= remaining_issue - 1'b1;
            end
            if (pop) begin
                remaining_xfer <= remaining_xfer - 1'b1;
                if (remaining_xfer == 1) done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_readdata;
    end

endmodule

// File: tb/tb_nios_system_tile_fetcher.sv
// Scoreboard bench for nios_system_tile_fetcher: a RAM model answers reads and a
// negedge monitor checks issued addresses and delivered words against queues.
module tb_nios_system_tile_fetcher;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_readdata;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    nios_system_tile_fetcher #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram[mem_address];
        else                mem_readdata <= 32'hDEAD_BEEF;
    end

    int total = 0;
    int bad   = 0;
    logic [31:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];
    int cyc = 0, cs_cnt = 0, cs_first = 0, cs_last = 0;
    int xfer_cnt = 0, last_xfer_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic busy_at_done = 1'b0;

    always @(negedge clk) begin
        logic          xnow;
        logic [31:0]   ed;
        logic [AW-1:0] ea;
        cyc++;
        if (reset !== 1'b1) begin
            xnow = out_valid && out_ready;
            if (mem_chipselect) begin
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL addr_unexpected: got %h, required none", mem_address);
                end else begin
                    ea = addr_q.pop_front();
                    if (mem_address !== ea) begin
                        bad++;
                        $display("FAIL addr_order: got %h, required %h", mem_address, ea);
                    end
                end
                total++;
                if (cs_cnt - xfer_cnt - (xnow ? 1 : 0) + 1 > DEPTH) begin
                    bad++;
                    $display("FAIL overissue: outstanding %0d, required <= %0d",
                             cs_cnt - xfer_cnt - (xnow ? 1 : 0) + 1, DEPTH);
                end
                if (cs_cnt == 0) cs_first = cyc;
                cs_last = cyc;
                cs_cnt++;
            end
            if (xnow) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL data_unexpected: got %h, required none", out_data);
                end else begin
                    ed = exp_q.pop_front();
                    if (out_data !== ed) begin
                        bad++;
                        $display("FAIL data_order: got %h, required %h", out_data, ed);
                    end
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input int n);
        @(posedge clk); #1;
        base_addr  = b;
        word_count = (AW+1)'(n);
        start      = 1'b1;
        cs_cnt     = 0;
        xfer_cnt   = 0;
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(AW'(int'(b) + i));
            exp_q.push_back(ram[(int'(b) + i) % 1024]);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > prev) ok = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; base_addr = 10'h055; word_count = 11'd3; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({out_valid, busy, done, mem_chipselect, mem_write} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b, required 00000",
                            {out_valid, busy, done, mem_chipselect, mem_write}); end
        total++; if (mem_address !== '0) begin
            bad++; $display("FAIL reset_addr: got %h, required 000", mem_address); end
        total++; if (out_data !== '0) begin
            bad++; $display("FAIL reset_data: got %h, required 0", out_data); end
        total++; if (mem_byteenable !== 4'hF) begin
            bad++; $display("FAIL byteenable: got %h, required f", mem_byteenable); end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || mem_chipselect !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL start_during_reset: busy=%b cs=%b done=%b, required 0 0 0",
                                busy, mem_chipselect, done); end
        end
    endtask

    task automatic test_basic;
        bit ok; int prev;
        out_ready = 1'b1; prev = done_cnt;
        start_burst(10'h010, 4);
        wait_done(prev, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout: got none, required done"); end
        total++; if (cs_cnt != 4 || cs_last - cs_first != 3) begin
            bad++; $display("FAIL basic_consecutive: got %0d reads over %0d cycles, required 4 over 3",
                            cs_cnt, cs_last - cs_first); end
        total++; if (done_cyc != last_xfer_cyc + 1) begin
            bad++; $display("FAIL basic_done_timing: got cycle %0d, required %0d",
                            done_cyc, last_xfer_cyc + 1); end
        total++; if (busy_at_done !== 1'b0) begin
            bad++; $display("FAIL basic_busy_at_done: got %b, required 0", busy_at_done); end
        total++; if (xfer_cnt != 4 || exp_q.size() != 0) begin
            bad++; $display("FAIL basic_count: got %0d words (%0d left), required 4 (0)",
                            xfer_cnt, exp_q.size()); end
    endtask

    task automatic test_wrap;
        bit ok; int prev;
        out_ready = 1'b1; prev = done_cnt;
        start_burst(10'h3FE, 4);
        wait_done(prev, 60, ok);
        total++; if (!ok || xfer_cnt != 4 || exp_q.size() != 0 || addr_q.size() != 0) begin
            bad++; $display("FAIL wrap_burst: got done=%0d words=%0d, required done=1 words=4",
                            ok, xfer_cnt); end
    endtask

    task automatic test_stall;
        bit ok; int prev;
        out_ready = 1'b0; prev = done_cnt;
        start_burst(10'h080, 8);
        repeat (20) @(posedge clk);
        #1;
        total++; if (cs_cnt != DEPTH) begin
            bad++; $display("FAIL stall_issue: got %0d reads, required %0d", cs_cnt, DEPTH); end
        total++; if (out_valid !== 1'b1 || xfer_cnt != 0) begin
            bad++; $display("FAIL stall_hold: got valid=%b xfers=%0d, required 1 0",
                            out_valid, xfer_cnt); end
        out_ready = 1'b1;
        wait_done(prev, 80, ok);
        total++; if (!ok || xfer_cnt != 8 || cs_cnt != 8 || exp_q.size() != 0) begin
            bad++; $display("FAIL stall_drain: got done=%0d words=%0d reads=%0d, required 1 8 8",
                            ok, xfer_cnt, cs_cnt); end
    endtask

    task automatic test_zero;
        int prev;
        prev = done_cnt;
        @(posedge clk); #1;
        base_addr = 10'h123; word_count = '0; start = 1'b1; cs_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done: got done=%b busy=%b, required 1 0", done, busy); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_after: got done=%b busy=%b, required 0 0", done, busy); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (cs_cnt != 0 || done_cnt != prev + 1) begin
            bad++; $display("FAIL zero_noaccess: got reads=%0d dones=%0d, required 0 1",
                            cs_cnt, done_cnt - prev); end
    endtask

    task automatic test_reset_mid;
        bit ok, seen; int prev;
        out_ready = 1'b1; seen = 1'b0;
        start_burst(10'h200, 6);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            if (xfer_cnt >= 2) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_progress: got %0d words, required 2", xfer_cnt); end
        #1; reset = 1'b1; prev = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); addr_q.delete();
        @(negedge clk);
        total++; if ({out_valid, busy, done, mem_chipselect} !== 4'b0 || mem_address !== '0 ||
                     out_data !== '0) begin
            bad++; $display("FAIL mid_reset_vals: got v/b/d/cs=%b addr=%h data=%h, required 0000 000 0",
                            {out_valid, busy, done, mem_chipselect}, mem_address, out_data); end
        repeat (4) @(negedge clk);
        total++; if (out_valid !== 1'b0 || done_cnt != prev) begin
            bad++; $display("FAIL mid_discard: got valid=%b dones=%0d, required 0 0",
                            out_valid, done_cnt - prev); end
        start_burst(10'h100, 2);
        wait_done(prev, 40, ok);
        total++; if (!ok || xfer_cnt != 2 || exp_q.size() != 0) begin
            bad++; $display("FAIL mid_restart: got done=%0d words=%0d, required 1 2", ok, xfer_cnt); end
    endtask

    task automatic test_ignored_start;
        bit ok; int prev;
        out_ready = 1'b1; prev = done_cnt;
        start_burst(10'h040, 5);
        @(posedge clk); #1;
        base_addr = 10'h300; word_count = 11'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(prev, 60, ok);
        repeat (5) @(posedge clk);
        #1;
        total++; if (!ok || xfer_cnt != 5 || cs_cnt != 5 || exp_q.size() != 0) begin
            bad++; $display("FAIL ignore_start: got done=%0d words=%0d reads=%0d, required 1 5 5",
                            ok, xfer_cnt, cs_cnt); end
        total++; if (busy !== 1'b0 || done_cnt != prev + 1) begin
            bad++; $display("FAIL ignore_idle: got busy=%b dones=%0d, required 0 1",
                            busy, done_cnt - prev); end
    endtask

    task automatic test_back_to_back;
        bit ok; int prev;
        prev = done_cnt; ok = 1'b0;
        start_burst(10'h3F8, 10);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (done_cnt > prev) ok = 1'b1;
        end
        total++; if (!ok || xfer_cnt != 10 || exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_random: got done=%0d words=%0d, required 1 10", ok, xfer_cnt); end
        out_ready = 1'b1;
        start_burst(10'h000, 3);
        wait_done(prev + 1, 40, ok);
        total++; if (!ok || xfer_cnt != 3 || exp_q.size() != 0 || done_cnt != prev + 2) begin
            bad++; $display("FAIL b2b_second: got done=%0d words=%0d, required 1 3", ok, xfer_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = $urandom ^ (i << 20);
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
